// File: rtl/multiword_add_sequencer_if.sv
// Operand, adder-slice and result handshake bundle for multiword_add_sequencer.
// Carries the ovf result bit only when MULTIWORD_ADD_OVF_EN is defined.
interface multiword_add_sequencer_if #(
  parameter int IWL    = 8,
  parameter int NSLICE = 4
) ();
  localparam int W = IWL * NSLICE;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_cin;
  logic [IWL-1:0] add_a;
  logic [IWL-1:0] add_b;
  logic           add_cin;
  logic [IWL-1:0] add_s;
  logic           add_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   sum;
  logic           cout;
`ifdef MULTIWORD_ADD_OVF_EN
  logic           ovf;
`endif

  // Sequencer side.
  modport slave (
    input  in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
`ifdef MULTIWORD_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, add_a, add_b, add_cin, out_valid, sum, cout
  );

  // Environment side: operand source, adder slice and result sink.
  modport master (
    output in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
`ifdef MULTIWORD_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, add_a, add_b, add_cin, out_valid, sum, cout
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add sequencer: one IWL-bit slice per cycle through an external adder, LSB first.
// Latency NSLICE cycles accept-to-out_valid; no overlap; optional ovf output under MULTIWORD_ADD_OVF_EN.
module multiword_add_sequencer #(
  parameter int IWL    = 8,
  parameter int NSLICE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multiword_add_sequencer_if.slave io_bus
);
  localparam int W    = IWL * NSLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic           r_carry;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic           r_out_valid;

  logic           w_in_ready;
  logic           w_load;
  logic           w_step;
  logic           w_last;
  logic           w_drain;
  logic [IWL-1:0] w_add_a;
  logic [IWL-1:0] w_add_b;
  logic           w_add_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (io_bus.out_ready) begin
          w_drain     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Adder inputs are quiet outside RUN so the external slice sees zeros when idle.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    if (r_state == S_RUN) begin
      w_add_cin = r_carry;
      for (int i = 0; i < NSLICE; i++) begin
        if (r_idx == IDXW'(i)) begin
          w_add_a = r_a[i*IWL +: IWL];
          w_add_b = r_b[i*IWL +: IWL];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_a     <= io_bus.op_a;
        r_b     <= io_bus.op_b;
        r_carry <= io_bus.op_cin;
        r_idx   <= '0;
      end
      if (w_step) begin
        for (int i = 0; i < NSLICE; i++) begin
          if (r_idx == IDXW'(i)) begin
            r_sum[i*IWL +: IWL] <= io_bus.add_s;
          end
        end
        r_carry <= io_bus.add_cout;
        // Index parks on the last slice; the next load clears it.
        if (!w_last) begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
      if (w_last) begin
        r_cout      <= io_bus.add_cout;
        r_out_valid <= 1'b1;
      end
      if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MULTIWORD_ADD_OVF_EN
  logic r_ovf;

  // Signed overflow: like-signed operands whose top result bit disagrees with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[W-1] == r_b[W-1]) && (io_bus.add_s[IWL-1] != r_a[W-1]);
    end
  end

  assign io_bus.ovf = r_ovf;
`endif

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.add_a     = w_add_a;
  assign io_bus.add_b     = w_add_b;
  assign io_bus.add_cin   = w_add_cin;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.sum       = r_sum;
  assign io_bus.cout      = r_cout;

endmodule
